decoder_controller: RTL and testbench

DECODER_CONTROLLER -- requirements
Module: decoder_controller

---
 rtl/decoder_pkg.sv | 22 ++
 rtl/decoder_watchdog.sv | 38 +++
 rtl/decoder_controller.sv | 122 ++++++++++++
 tb/tb_decoder_controller.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the file decoder controller: state encoding and sizing defaults.
package decoder_pkg;

  localparam int ROUNDS_DEF  = 24;
  localparam int TIMEOUT_DEF = 1024;
  localparam int ITER_W      = 5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_RC,
    S_RE,
    S_PE,
    S_RO,
    S_CP,
    S_NEXT,
    S_STORE,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/decoder_watchdog.sv
// Per-step cycle counter: cleared on step entry, flags the first cycle and the timeout cycle.
module decoder_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o,
  output logic first_o
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturate at the timeout value so the counter can never wrap back to "first cycle".
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign first_o   = (cnt_q == '0);

endmodule

// File: rtl/decoder_controller.sv
// Sequences the inverse rounds of one file through the datapath sub-steps, with a per-step watchdog.
module decoder_controller
  import decoder_pkg::*;
#(
  parameter int ROUNDS  = ROUNDS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [9:0]        file_index,
  output logic [9:0]        file_index_q,
  output logic              LD_start,
  output logic              RC_start,
  output logic              RE_start,
  output logic              PE_start,
  output logic              RO_start,
  output logic              CP_start,
  output logic              ST_start,
  input  logic              LD_finish,
  input  logic              RC_finish,
  input  logic              RE_finish,
  input  logic              PE_finish,
  input  logic              RO_finish,
  input  logic              CP_finish,
  input  logic              ST_finish,
  output logic [ITER_W-1:0] iteration,
  output logic              busy,
  output logic              finish,
  output logic              error
);

  state_e             state_q, state_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [9:0]         file_index_d;
  logic               is_step, step_fin, wd_first, wd_expired;
  state_e             step_nxt;

  decoder_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clear_i   (!is_step || (state_d != state_q)),
    .enable_i  (is_step),
    .expired_o (wd_expired),
    .first_o   (wd_first)
  );

  always_comb begin
    is_step  = 1'b1;
    step_fin = 1'b0;
    step_nxt = state_q;
    case (state_q)
      S_LOAD:  begin step_fin = LD_finish; step_nxt = S_RC;    end
      S_RC:    begin step_fin = RC_finish; step_nxt = S_RE;    end
      S_RE:    begin step_fin = RE_finish; step_nxt = S_PE;    end
      S_PE:    begin step_fin = PE_finish; step_nxt = S_RO;    end
      S_RO:    begin step_fin = RO_finish; step_nxt = S_CP;    end
      S_CP:    begin step_fin = CP_finish; step_nxt = S_NEXT;  end
      S_STORE: begin step_fin = ST_finish; step_nxt = S_DONE;  end
      default: is_step = 1'b0;
    endcase
  end

  // A finish in the start-pulse cycle is ignored; a valid finish beats a coincident timeout.
  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    file_index_d = file_index_q;
    if (is_step) begin
      if (step_fin && !wd_first) begin
        state_d = step_nxt;
      end else if (wd_expired) begin
        state_d = S_ERR;
      end
    end else begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (start) begin
            file_index_d = file_index;
            iter_d       = ITER_W'(ROUNDS - 1);
            state_d      = S_LOAD;
          end
        end
        S_NEXT: begin
          if (iter_q == '0) begin
            state_d = S_STORE;
          end else begin
            iter_d  = iter_q - ITER_W'(1);
            state_d = S_RC;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      iter_q       <= '0;
      file_index_q <= '0;
    end else begin
      state_q      <= state_d;
      iter_q       <= iter_d;
      file_index_q <= file_index_d;
    end
  end

  assign LD_start  = (state_q == S_LOAD)  && wd_first;
  assign RC_start  = (state_q == S_RC)    && wd_first;
  assign RE_start  = (state_q == S_RE)    && wd_first;
  assign PE_start  = (state_q == S_PE)    && wd_first;
  assign RO_start  = (state_q == S_RO)    && wd_first;
  assign CP_start  = (state_q == S_CP)    && wd_first;
  assign ST_start  = (state_q == S_STORE) && wd_first;
  assign iteration = iter_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_ERR);
  assign finish    = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);

endmodule

// File: tb/tb_decoder_controller.sv
// Scoreboard bench for decoder_controller: a datapath responder answers start pulses, a monitor checks outcomes.
module tb_decoder_controller;

  typedef struct {
    bit         is_err;
    int         cyc;
    logic [9:0] fidx;
  } exp_t;

  logic       clk, rst, start;
  logic [9:0] file_index, file_index_q;
  logic [4:0] iteration;
  logic       busy, finish, error;
  logic [6:0] fin_v;
  wire  [6:0] st_v;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  int   lat[7];
  bit   early[7];
  bit   hold[7];
  int   rcnt[7];
  int   pulse_cnt[7];
  int   fin_cnt = 0;
  int   exp_iter = 0;
  bit   chk_iter = 0;
  int   exp_pe_len = 2;
  int   pe_cyc = 0;
  bit   err_prev = 0;

  decoder_controller dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .file_index   (file_index),
    .file_index_q (file_index_q),
    .LD_start     (st_v[0]),
    .RC_start     (st_v[1]),
    .RE_start     (st_v[2]),
    .PE_start     (st_v[3]),
    .RO_start     (st_v[4]),
    .CP_start     (st_v[5]),
    .ST_start     (st_v[6]),
    .LD_finish    (fin_v[0]),
    .RC_finish    (fin_v[1]),
    .RE_finish    (fin_v[2]),
    .PE_finish    (fin_v[3]),
    .RO_finish    (fin_v[4]),
    .CP_finish    (fin_v[5]),
    .ST_finish    (fin_v[6]),
    .iteration    (iteration),
    .busy         (busy),
    .finish       (finish),
    .error        (error)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Datapath model: each step answers lat[i] cycles after its start pulse.
  initial begin
    fin_v = '0;
    for (int i = 0; i < 7; i++) rcnt[i] = 0;
    forever begin
      @(negedge clk);
      fin_v = '0;
      if (!rst) begin
        for (int i = 0; i < 7; i++) rcnt[i] = 0;
      end else begin
        for (int i = 0; i < 7; i++) begin
          if (rcnt[i] > 0) begin
            rcnt[i]--;
            if (rcnt[i] == 0 && !hold[i]) fin_v[i] = 1'b1;
          end
          if (st_v[i]) begin
            rcnt[i] = lat[i];
            if (early[i]) fin_v[i] = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every finish pulse or error entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 7; i++) if (st_v[i]) pulse_cnt[i]++;
        if (finish) fin_cnt++;
        if (st_v[1] && chk_iter) begin
          check("iteration_at_RC", int'(iteration), exp_iter);
          exp_iter--;
        end
        if (st_v[3]) pe_cyc = cyc;
        if (st_v[4]) check("pe_duration", cyc - pe_cyc, exp_pe_len);
        if (finish || (error && !err_prev)) begin
          if (sb.size() == 0) begin
            check("unexpected_outcome", 1, 0);
          end else begin
            e = sb.pop_front();
            check("outcome_is_error", int'(error), int'(e.is_err));
            check("outcome_cycle", cyc, e.cyc);
            check("file_index_q", int'(file_index_q), int'(e.fidx));
            if (error) begin
              check("busy_in_err", int'(busy), 0);
              check("finish_in_err", int'(finish), 0);
            end
          end
        end
        err_prev = error;
      end else begin
        err_prev = 0;
      end
    end
  end

  task automatic set_lat(input int re_lat, input int pe_lat, input bit pe_early, input bit ro_hold);
    for (int i = 0; i < 7; i++) begin
      lat[i] = 1;
      early[i] = 0;
      hold[i] = 0;
    end
    lat[2] = re_lat;
    lat[3] = pe_lat;
    early[3] = pe_early;
    hold[4] = ro_hold;
    exp_pe_len = pe_early ? pe_lat + 1 : pe_lat + 1;
  endtask

  task automatic run(input logic [9:0] fidx, input int dur, input bit is_err);
    exp_t e;
    for (int i = 0; i < 7; i++) pulse_cnt[i] = 0;
    exp_iter = 23;
    chk_iter = 1;
    start = 1;
    file_index = fidx;
    e.is_err = is_err;
    e.cyc = cyc + dur;
    e.fidx = fidx;
    sb.push_back(e);
    @(negedge clk);
    start = 0;
    file_index = 10'h3FF;
  endtask

  task automatic wait_sb(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_counts();
    check("LD_pulses", pulse_cnt[0], 1);
    check("RC_pulses", pulse_cnt[1], 24);
    check("RE_pulses", pulse_cnt[2], 24);
    check("PE_pulses", pulse_cnt[3], 24);
    check("RO_pulses", pulse_cnt[4], 24);
    check("CP_pulses", pulse_cnt[5], 24);
    check("ST_pulses", pulse_cnt[6], 1);
  endtask

  initial begin
    int n;
    start = 0;
    file_index = 0;
    set_lat(1, 1, 0, 0);
    rst = 1;
    #2 rst = 0;
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_finish", int'(finish), 0);
    check("rst_error", int'(error), 0);
    check("rst_iteration", int'(iteration), 0);
    check("rst_file_index_q", int'(file_index_q), 0);
    check("rst_starts", int'(st_v), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);

    // nominal
    run(10'd37, 269, 0);
    wait_sb(400);
    check_counts();
    check("iter_final", int'(iteration), 0);
    repeat (3) @(negedge clk);

    // slow RE step
    set_lat(5, 1, 0, 0);
    run(10'd100, 365, 0);
    wait_sb(500);
    check_counts();
    repeat (3) @(negedge clk);

    // PE finish in its start cycle must not advance
    set_lat(1, 3, 1, 0);
    run(10'd512, 317, 0);
    wait_sb(450);
    check_counts();
    repeat (3) @(negedge clk);

    // start while busy in CP is ignored
    set_lat(1, 1, 0, 0);
    run(10'd37, 269, 0);
    n = 0;
    while (!st_v[5] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cp_reached", int'(st_v[5]), 1);
    start = 1;
    file_index = 10'd99;
    @(negedge clk);
    start = 0;
    wait_sb(400);
    check_counts();
    repeat (3) @(negedge clk);

    // RO never finishes: watchdog error, then recover
    set_lat(1, 1, 0, 1);
    run(10'd200, 1033, 1);
    wait_sb(1200);
    chk_iter = 0;
    repeat (20) @(negedge clk);
    check("err_held", int'(error), 1);
    check("err_busy", int'(busy), 0);
    check("err_no_finish", fin_cnt, 4);
    set_lat(1, 1, 0, 0);
    run(10'd5, 269, 0);
    check("err_cleared", int'(error), 0);
    check("busy_after_recover", int'(busy), 1);
    wait_sb(400);
    check_counts();
    repeat (3) @(negedge clk);

    // reset in round 10
    for (int i = 0; i < 7; i++) pulse_cnt[i] = 0;
    exp_iter = 23;
    chk_iter = 1;
    start = 1;
    file_index = 10'd77;
    @(negedge clk);
    start = 0;
    n = 0;
    while (!(st_v[1] && iteration == 5'd10) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("round10_reached", int'(iteration), 10);
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_finish", int'(finish), 0);
    check("mid_rst_error", int'(error), 0);
    check("mid_rst_iteration", int'(iteration), 0);
    check("mid_rst_file_index_q", int'(file_index_q), 0);
    check("mid_rst_starts", int'(st_v), 0);
    chk_iter = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 7; i++) pulse_cnt[i] = 0;
    fin_cnt = 0;
    rst = 1;
    repeat (300) @(negedge clk);
    n = 0;
    for (int i = 0; i < 7; i++) n += pulse_cnt[i];
    check("post_rst_pulses", n, 0);
    check("post_rst_finish", fin_cnt, 0);
    check("post_rst_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
